// File: rtl/branch_unit_pkg.sv
// rtl/branch_unit_pkg.sv - shared constants, state type and branch condition helper for branch_unit
//
// Contents:
//   EQ_IDX/LTS_IDX/LTU_IDX  bit positions inside the ALU comparison flag vector
//   F3_*                    RV32I conditional branch funct3 encodings
//   state_t                 IDLE / REDIRECT / FLUSH recovery states
//   branch_taken()          taken decision for a conditional branch from funct3 and ALU flags

package branch_unit_pkg;

    localparam int EQ_IDX  = 0;
    localparam int LTS_IDX = 1;
    localparam int LTU_IDX = 2;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    // Reserved encodings 010/011 resolve as not taken.
    function automatic logic branch_taken(input logic [2:0] funct3, input logic [2:0] flags);
        logic t;
        case (funct3)
            F3_BEQ:  t = flags[EQ_IDX];
            F3_BNE:  t = !flags[EQ_IDX];
            F3_BLT:  t = flags[LTS_IDX];
            F3_BGE:  t = !flags[LTS_IDX];
            F3_BLTU: t = flags[LTU_IDX];
            F3_BGEU: t = !flags[LTU_IDX];
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/branch_unit_bht.sv
// rtl/branch_unit_bht.sv - branch history table of 2-bit saturating counters (module branch_bht)
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset (all counters -> 01)
//   lookup_idx     fetch-side table index
//   lookup_taken   counter[1] of the looked-up entry (combinational, pre-update value)
//   update_en      one conditional branch resolved this cycle
//   update_idx     index of the resolved branch
//   update_taken   resolved direction: increment if 1, decrement if 0, saturating

module branch_bht #(
    parameter int BHT_IDX_W = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BHT_IDX_W-1:0] lookup_idx,
    output logic                 lookup_taken,
    input  logic                 update_en,
    input  logic [BHT_IDX_W-1:0] update_idx,
    input  logic                 update_taken
);

    localparam int ENTRIES = 1 << BHT_IDX_W;

    logic [1:0] ctr [ENTRIES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= 2'b01;
            end
        end else if (update_en) begin
            if (update_taken && ctr[update_idx] != 2'b11) begin
                ctr[update_idx] <= ctr[update_idx] + 2'd1;
            end else if (!update_taken && ctr[update_idx] != 2'b00) begin
                ctr[update_idx] <= ctr[update_idx] - 2'd1;
            end
        end
    end

    // Read the array directly: a lookup in the update cycle sees the old counter.
    assign lookup_taken = ctr[lookup_idx][1];

endmodule

// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - execute-stage branch/jump resolution with redirect and fixed-length flush
//
// Optional feature macro: BRANCH_PREDICT_EN (adds branch_bht predictor table).
//
// Parameters:
//   FLUSH_CYCLES   cycles flush_o is held after the redirect is accepted (>=1)
//   BHT_IDX_W      log2 of predictor entries (BRANCH_PREDICT_EN only)
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   valid_i / ready_o               execute-stage handshake; ready_o high only in IDLE
//   is_branch_i/is_jal_i/is_jalr_i  instruction type (at most one set)
//   funct3_i, alu_branch_i          branch condition and ALU flags {LTU,LTS,EQ}
//   pc_i, imm_i, rs1_i              target operands
//   pred_taken_i                    fetch prediction for this instruction
//   redirect_valid_o/redirect_pc_o  held redirect to fetch, accepted by redirect_ready_i
//   flush_o                         kill IF/ID for FLUSH_CYCLES cycles after redirect
//   lookup_pc_i / lookup_taken_o    fetch-side prediction lookup (combinational)

module branch_unit
    import branch_unit_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int BHT_IDX_W    = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        is_branch_i,
    input  logic        is_jal_i,
    input  logic        is_jalr_i,
    input  logic [2:0]  funct3_i,
    input  logic [2:0]  alu_branch_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] imm_i,
    input  logic [31:0] rs1_i,
    input  logic        pred_taken_i,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    input  logic        redirect_ready_i,
    output logic        flush_o,
    input  logic [31:0] lookup_pc_i,
    output logic        lookup_taken_o
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       redirect_pc_q;

    logic              accept;
    logic              taken;
    logic              mispredict;
    logic [31:0]       target;
    logic [31:0]       next_pc;

    assign ready_o          = (state == IDLE);
    assign flush_o          = (state == FLUSH);
    assign redirect_valid_o = (state == REDIRECT);
    assign redirect_pc_o    = redirect_pc_q;

    assign accept     = valid_i && ready_o && (is_branch_i || is_jal_i || is_jalr_i);
    assign taken      = is_jal_i || is_jalr_i || (is_branch_i && branch_taken(funct3_i, alu_branch_i));
    // Fetch carries no target for JALR, so it always needs a redirect.
    assign mispredict = (taken != pred_taken_i) || is_jalr_i;
    assign target     = is_jalr_i ? ((rs1_i + imm_i) & ~32'h1) : (pc_i + imm_i);
    assign next_pc    = taken ? target : (pc_i + 32'd4);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            redirect_pc_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && mispredict) begin
                        redirect_pc_q <= next_pc;
                        state         <= REDIRECT;
                    end
                end
                REDIRECT: begin
                    if (redirect_ready_i) begin
                        cnt   <= CNT_INIT;
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BRANCH_PREDICT_EN
    branch_bht #(
        .BHT_IDX_W (BHT_IDX_W)
    ) u_bht (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_idx   (lookup_pc_i[BHT_IDX_W+1:2]),
        .lookup_taken (lookup_taken_o),
        .update_en    (accept && is_branch_i),
        .update_idx   (pc_i[BHT_IDX_W+1:2]),
        .update_taken (taken)
    );

    logic unused_lookup_bits;
    assign unused_lookup_bits = ^{lookup_pc_i[31:BHT_IDX_W+2], lookup_pc_i[1:0]};
`else
    // No table: fetch predicts not-taken everywhere.
    assign lookup_taken_o = 1'b0;

    logic unused_lookup;
    assign unused_lookup = ^{lookup_pc_i, 32'(BHT_IDX_W)};
`endif

endmodule
